// File: rtl/frontend_pkg.sv
// Shared types and constants for the TVP7002 frontend sync-lock sequencer:
// state encoding, measurement widths and the packed mode-measurement record.
package frontend_pkg;

    localparam int VT_W = 11;
    localparam int PC_W = 20;
    localparam int HW_W = 8;

    typedef enum logic [1:0] {
        ST_NOSYNC  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } lock_state_e;

    typedef struct packed {
        logic            interlace;
        logic [VT_W-1:0] vtotal;
        logic [PC_W-1:0] pcnt_frame;
        logic [HW_W-1:0] hsync_width;
    } mode_meas_t;

    // Unsigned distance without wrap-around; narrower fields are zero-extended.
    function automatic logic [PC_W-1:0] abs_diff(input logic [PC_W-1:0] a,
                                                 input logic [PC_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/frontend_lock_ctrl_if.sv
// Measurement/status bundle between the frontend measurement logic (master)
// and the sync-lock sequencer (slave).
interface frontend_lock_ctrl_if;
    import frontend_pkg::*;

    logic            frame_strobe_i;
    logic            sync_active_i;
    logic            interlace_i;
    logic [VT_W-1:0] vtotal_i;
    logic [PC_W-1:0] pcnt_frame_i;
    logic [HW_W-1:0] hsync_width_i;

    logic            lock_o;
    logic [1:0]      state_o;
    logic            mode_change_o;
    logic            unlock_o;
    logic            timeout_o;
    logic [VT_W-1:0] lk_vtotal_o;
    logic [PC_W-1:0] lk_pcnt_frame_o;
    logic [HW_W-1:0] lk_hsync_width_o;
    logic            lk_interlace_o;

    modport master (
        output frame_strobe_i, sync_active_i, interlace_i,
               vtotal_i, pcnt_frame_i, hsync_width_i,
        input  lock_o, state_o, mode_change_o, unlock_o, timeout_o,
               lk_vtotal_o, lk_pcnt_frame_o, lk_hsync_width_o, lk_interlace_o
    );

    modport slave (
        input  frame_strobe_i, sync_active_i, interlace_i,
               vtotal_i, pcnt_frame_i, hsync_width_i,
        output lock_o, state_o, mode_change_o, unlock_o, timeout_o,
               lk_vtotal_o, lk_pcnt_frame_o, lk_hsync_width_o, lk_interlace_o
    );

endinterface

// File: rtl/meas_match.sv
// Combinational tolerance comparator: two measurement sets match when the
// interlace flags agree and every numeric field is within its tolerance.
module meas_match
    import frontend_pkg::*;
(
    input  mode_meas_t      a_i,
    input  mode_meas_t      b_i,
    input  logic [VT_W-1:0] vtotal_tol_i,
    input  logic [PC_W-1:0] pcnt_tol_i,
    input  logic [HW_W-1:0] hsw_tol_i,
    output logic            match_o
);

    logic [PC_W-1:0] d_vt;
    logic [PC_W-1:0] d_pc;
    logic [PC_W-1:0] d_hw;

    assign d_vt = abs_diff(PC_W'(a_i.vtotal), PC_W'(b_i.vtotal));
    assign d_pc = abs_diff(a_i.pcnt_frame, b_i.pcnt_frame);
    assign d_hw = abs_diff(PC_W'(a_i.hsync_width), PC_W'(b_i.hsync_width));

    assign match_o = (a_i.interlace == b_i.interlace)
                  && (d_vt <= PC_W'(vtotal_tol_i))
                  && (d_pc <= pcnt_tol_i)
                  && (d_hw <= PC_W'(hsw_tol_i));

endmodule

// File: rtl/frontend_lock_ctrl.sv
// Sync-lock sequencer for the TVP7002 capture frontend (CLK_MEAS_i domain).
// Qualifies per-frame measurements, locks after STABLE_FRAMES matching frames,
// unlocks after MISS_FRAMES mismatches or on sync loss.
// Optional missing-frame watchdog: define FRONTEND_LOCK_TIMEOUT_EN.
module frontend_lock_ctrl
    import frontend_pkg::*;
#(
    parameter int STABLE_FRAMES  = 4,
    parameter int MISS_FRAMES    = 2,
    parameter int VTOTAL_TOL     = 1,
    parameter int PCNT_TOL       = 256,
    parameter int HSW_TOL        = 4,
    parameter int TIMEOUT_CYCLES = 2700000
) (
    input  logic                 CLK_MEAS_i,
    input  logic                 reset_n,
    frontend_lock_ctrl_if.slave  bus
);

    localparam logic [3:0]      STABLE_LAST = 4'(STABLE_FRAMES - 1);
    localparam logic [3:0]      MISS_LIM    = 4'(MISS_FRAMES);
    localparam logic [VT_W-1:0] VT_TOL      = VT_W'(VTOTAL_TOL);
    localparam logic [PC_W-1:0] PC_TOL      = PC_W'(PCNT_TOL);
    localparam logic [HW_W-1:0] HW_TOL      = HW_W'(HSW_TOL);

    lock_state_e state_q, state_d;
    logic [3:0]  stable_ctr_q, stable_ctr_d, stable_inc;
    logic [3:0]  miss_ctr_q, miss_ctr_d, miss_inc;
    logic        reload_q, reload_d;
    mode_meas_t  cand_q, cand_d;
    mode_meas_t  lk_q, lk_d;
    logic        lock_q, lock_d;
    logic        mode_change_q, mode_change_d;
    logic        unlock_q, unlock_d;
    mode_meas_t  meas;
    logic        cand_match, lk_match;
    logic        timeout_hit;

    assign meas = {bus.interlace_i, bus.vtotal_i, bus.pcnt_frame_i, bus.hsync_width_i};

    meas_match u_cand_match (
        .a_i(meas), .b_i(cand_q),
        .vtotal_tol_i(VT_TOL), .pcnt_tol_i(PC_TOL), .hsw_tol_i(HW_TOL),
        .match_o(cand_match)
    );

    meas_match u_lk_match (
        .a_i(meas), .b_i(lk_q),
        .vtotal_tol_i(VT_TOL), .pcnt_tol_i(PC_TOL), .hsw_tol_i(HW_TOL),
        .match_o(lk_match)
    );

    // Counters saturate at all-ones instead of wrapping.
    assign stable_inc = (stable_ctr_q == 4'hF) ? stable_ctr_q : stable_ctr_q + 4'd1;
    assign miss_inc   = (miss_ctr_q   == 4'hF) ? miss_ctr_q   : miss_ctr_q   + 4'd1;

`ifdef FRONTEND_LOCK_TIMEOUT_EN
    localparam logic [21:0] WD_LAST = 22'(TIMEOUT_CYCLES - 1);
    logic [21:0] wd_q, wd_d;
    logic        timeout_q;

    // Missing-frame counter: restarts on every strobe and while idle in NOSYNC.
    always_comb begin
        wd_d = wd_q;
        if (bus.frame_strobe_i || state_q == ST_NOSYNC) begin
            wd_d = '0;
        end else if (wd_q != '1) begin
            wd_d = wd_q + 22'd1;
        end
    end

    // Fires on the cycle whose edge would complete TIMEOUT_CYCLES without a frame.
    assign timeout_hit = (state_q != ST_NOSYNC) && (wd_q >= WD_LAST);

    // Watchdog register and sticky flag; a fresh lock clears the flag.
    always_ff @(posedge CLK_MEAS_i or negedge reset_n) begin
        if (!reset_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            if (timeout_hit && bus.sync_active_i) begin
                timeout_q <= 1'b1;
            end else if (mode_change_d) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    assign timeout_hit   = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    // Next-state logic: sync loss beats timeout, which beats strobe processing.
    always_comb begin
        state_d       = state_q;
        stable_ctr_d  = stable_ctr_q;
        miss_ctr_d    = miss_ctr_q;
        reload_d      = reload_q;
        cand_d        = cand_q;
        lk_d          = lk_q;
        lock_d        = lock_q;
        mode_change_d = 1'b0;
        unlock_d      = 1'b0;
        case (state_q)
            ST_NOSYNC: begin
                stable_ctr_d = '0;
                miss_ctr_d   = '0;
                if (bus.sync_active_i) begin
                    state_d  = ST_ACQUIRE;
                    reload_d = 1'b1;
                end
            end
            ST_ACQUIRE: begin
                if (!bus.sync_active_i || timeout_hit) begin
                    state_d      = ST_NOSYNC;
                    stable_ctr_d = '0;
                    miss_ctr_d   = '0;
                    reload_d     = 1'b0;
                end else if (bus.frame_strobe_i) begin
                    if (reload_q || !cand_match) begin
                        cand_d       = meas;
                        stable_ctr_d = '0;
                        reload_d     = 1'b0;
                    end else begin
                        stable_ctr_d = stable_inc;
                        if (stable_inc >= STABLE_LAST) begin
                            state_d       = ST_LOCKED;
                            lock_d        = 1'b1;
                            lk_d          = cand_q;
                            mode_change_d = 1'b1;
                            miss_ctr_d    = '0;
                        end
                    end
                end
            end
            ST_LOCKED: begin
                if (!bus.sync_active_i || timeout_hit) begin
                    state_d      = ST_NOSYNC;
                    lock_d       = 1'b0;
                    unlock_d     = 1'b1;
                    stable_ctr_d = '0;
                    miss_ctr_d   = '0;
                end else if (bus.frame_strobe_i) begin
                    if (lk_match) begin
                        miss_ctr_d = '0;
                    end else if (miss_inc >= MISS_LIM) begin
                        // Persistent mismatch: start acquiring the new mode at once.
                        state_d      = ST_ACQUIRE;
                        lock_d       = 1'b0;
                        unlock_d     = 1'b1;
                        cand_d       = meas;
                        stable_ctr_d = '0;
                        miss_ctr_d   = '0;
                        reload_d     = 1'b0;
                    end else begin
                        miss_ctr_d = miss_inc;
                    end
                end
            end
            default: begin
                state_d = ST_NOSYNC;
                lock_d  = 1'b0;
            end
        endcase
    end

    // State, counters, candidate and locked-mode registers.
    always_ff @(posedge CLK_MEAS_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_NOSYNC;
            stable_ctr_q  <= '0;
            miss_ctr_q    <= '0;
            reload_q      <= 1'b0;
            cand_q        <= '0;
            lk_q          <= '0;
            lock_q        <= 1'b0;
            mode_change_q <= 1'b0;
            unlock_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            stable_ctr_q  <= stable_ctr_d;
            miss_ctr_q    <= miss_ctr_d;
            reload_q      <= reload_d;
            cand_q        <= cand_d;
            lk_q          <= lk_d;
            lock_q        <= lock_d;
            mode_change_q <= mode_change_d;
            unlock_q      <= unlock_d;
        end
    end

    assign bus.state_o          = state_q;
    assign bus.lock_o           = lock_q;
    assign bus.mode_change_o    = mode_change_q;
    assign bus.unlock_o         = unlock_q;
    assign bus.lk_vtotal_o      = lk_q.vtotal;
    assign bus.lk_pcnt_frame_o  = lk_q.pcnt_frame;
    assign bus.lk_hsync_width_o = lk_q.hsync_width;
    assign bus.lk_interlace_o   = lk_q.interlace;

endmodule
